dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its CPU, debug, RAM and I/O neighbours.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dmem_arbiter_if;
  logic       cpu_req_i;
  logic [4:0] cpu_addr_i;
  logic       cpu_we_i;
  logic [7:0] cpu_wdata_i;
  logic [7:0] cpu_rdata_o;
  logic       cpu_hold_o;

  logic       dbg_req_i;
  logic [4:0] dbg_addr_i;
  logic       dbg_we_i;
  logic [7:0] dbg_wdata_i;
  logic       dbg_ack_o;
  logic [7:0] dbg_rdata_o;

  logic [3:0] ram_addr_o;
  logic [7:0] ram_data_o;
  logic       ram_we_o;
  logic [7:0] ram_data_i;

  logic [3:0] io_addr_o;
  logic [7:0] io_data_o;
  logic       io_we_o;
  logic       io_re_o;
  logic [7:0] io_data_i;

  logic       fsm_state_o;

  modport slave (
    input  cpu_req_i, cpu_addr_i, cpu_we_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_hold_o,
    input  dbg_req_i, dbg_addr_i, dbg_we_i, dbg_wdata_i,
    output dbg_ack_o, dbg_rdata_o,
    output ram_addr_o, ram_data_o, ram_we_o,
    input  ram_data_i,
    output io_addr_o, io_data_o, io_we_o, io_re_o,
    input  io_data_i,
    output fsm_state_o
  );

  modport master (
    output cpu_req_i, cpu_addr_i, cpu_we_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_hold_o,
    output dbg_req_i, dbg_addr_i, dbg_we_i, dbg_wdata_i,
    input  dbg_ack_o, dbg_rdata_o,
    input  ram_addr_o, ram_data_o, ram_we_o,
    output ram_data_i,
    input  io_addr_o, io_data_o, io_we_o, io_re_o,
    output io_data_i,
    input  fsm_state_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one RAM/I-O port between the CPU (default owner) and a debug requester.
// Handshake: debug holds dbg_req_i until dbg_ack_o pulses one cycle after its grant.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state_q;
  logic [2:0] starve_q;
  logic [2:0] starve_d;
  logic       ack_q;
  logic [7:0] dbg_rdata_q;

  logic       dbg_grant;
  logic       owner_req;
  logic [4:0] owner_addr;
  logic       owner_we;
  logic [7:0] owner_wdata;
  logic [7:0] dbg_read_mux;

  // Reset gates the grant so nothing is accessed while rst_i is high.
  assign dbg_grant = !rst_i && (state_q == IDLE) && bus.dbg_req_i &&
                     (!bus.cpu_req_i || (starve_q == LIMIT));

  always_comb begin
    owner_req   = 1'b0;
    owner_addr  = bus.cpu_addr_i;
    owner_we    = bus.cpu_we_i;
    owner_wdata = bus.cpu_wdata_i;
    if (dbg_grant) begin
      owner_req   = 1'b1;
      owner_addr  = bus.dbg_addr_i;
      owner_we    = bus.dbg_we_i;
      owner_wdata = bus.dbg_wdata_i;
    end else begin
      owner_req   = bus.cpu_req_i && !rst_i;
    end
  end

  assign bus.ram_addr_o = owner_addr[3:0];
  assign bus.io_addr_o  = owner_addr[3:0];
  assign bus.ram_data_o = owner_wdata;
  assign bus.io_data_o  = owner_wdata;
  assign bus.ram_we_o   = owner_req &&  owner_we && !owner_addr[4];
  assign bus.io_we_o    = owner_req &&  owner_we &&  owner_addr[4];
  assign bus.io_re_o    = owner_req && !owner_we &&  owner_addr[4];

  assign bus.cpu_rdata_o = bus.cpu_addr_i[4] ? bus.io_data_i : bus.ram_data_i;
  assign bus.cpu_hold_o  = bus.cpu_req_i && dbg_grant;
  assign dbg_read_mux    = bus.dbg_addr_i[4] ? bus.io_data_i : bus.ram_data_i;

  // Counts cycles a pending debug request has been passed over for the CPU.
  always_comb begin
    starve_d = starve_q;
    if (!bus.dbg_req_i || dbg_grant) begin
      starve_d = 3'd0;
    end else if ((state_q == IDLE) && (starve_q != LIMIT)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      starve_q    <= 3'd0;
      ack_q       <= 1'b0;
      dbg_rdata_q <= 8'h00;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        IDLE: begin
          if (dbg_grant) begin
            state_q     <= ACK;
            ack_q       <= 1'b1;
            dbg_rdata_q <= bus.dbg_we_i ? 8'h00 : dbg_read_mux;
          end else begin
            ack_q <= 1'b0;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dbg_ack_o   = ack_q;
  assign bus.dbg_rdata_o = dbg_rdata_q;
  assign bus.fsm_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a cycle-level
// model holding RAM/I-O contents, pending-ack flag and debug wait count.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram_mem [16];
  logic [7:0] io_mem  [16];
  always @(posedge clk) begin
    if (bus.ram_we_o) ram_mem[bus.ram_addr_o] <= bus.ram_data_o;
    if (bus.io_we_o)  io_mem[bus.io_addr_o]   <= bus.io_data_o;
  end
  assign bus.ram_data_i = ram_mem[bus.ram_addr_o];
  assign bus.io_data_i  = io_mem[bus.io_addr_o] ^ 8'h5A;

  int n_checks;
  int n_pass;

  // Reference model state
  bit         m_ack;
  int         m_wait;
  logic [7:0] m_rdata;
  logic [7:0] m_ram [16];
  logic [7:0] m_io  [16];

  // Expectations for the current cycle
  bit         e_grant, e_ram_we, e_io_we, e_io_re, e_hold;
  logic [3:0] e_addr;
  logic [7:0] e_wdata, e_cpu_rdata;
  bit         e_owner_we;
  logic [4:0] e_owner_addr;

  task automatic calc_exp();
    bit act;
    e_grant = !rst && !m_ack && bus.dbg_req_i && (!bus.cpu_req_i || m_wait == LIMIT);
    act = e_grant || (!rst && bus.cpu_req_i);
    e_owner_addr = e_grant ? bus.dbg_addr_i : bus.cpu_addr_i;
    e_owner_we   = e_grant ? bus.dbg_we_i : bus.cpu_we_i;
    e_wdata      = e_grant ? bus.dbg_wdata_i : bus.cpu_wdata_i;
    e_addr       = e_owner_addr[3:0];
    e_ram_we = act && e_owner_we && !e_owner_addr[4];
    e_io_we  = act && e_owner_we && e_owner_addr[4];
    e_io_re  = act && !e_owner_we && e_owner_addr[4];
    e_hold   = bus.cpu_req_i && e_grant;
    e_cpu_rdata = bus.cpu_addr_i[4] ? (m_io[e_addr] ^ 8'h5A) : m_ram[e_addr];
  endtask

  task automatic model_reset();
    m_ack = 0;
    m_wait = 0;
    m_rdata = 8'h00;
  endtask

  // Advance the model over the coming edge, then land #1 after it.
  task automatic tick();
    calc_exp();
    if (rst) begin
      model_reset();
    end else begin
      if (e_grant)
        m_rdata = bus.dbg_we_i ? 8'h00 :
                  (bus.dbg_addr_i[4] ? (m_io[bus.dbg_addr_i[3:0]] ^ 8'h5A) : m_ram[bus.dbg_addr_i[3:0]]);
      if (e_ram_we) m_ram[e_addr] = e_wdata;
      if (e_io_we)  m_io[e_addr]  = e_wdata;
      if (!bus.dbg_req_i || e_grant) m_wait = 0;
      else if (!m_ack && m_wait < LIMIT) m_wait++;
      m_ack = e_grant;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cpu_req_i = 0; bus.cpu_addr_i = '0; bus.cpu_we_i = 0; bus.cpu_wdata_i = '0;
    bus.dbg_req_i = 0; bus.dbg_addr_i = '0; bus.dbg_we_i = 0; bus.dbg_wdata_i = '0;
  endtask

  task automatic test_reset();
    bus.cpu_req_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 5'h03; bus.cpu_wdata_i = 8'hFF;
    bus.dbg_req_i = 1; bus.dbg_addr_i = 5'h13; bus.dbg_we_i = 1;
    #4;
    n_checks++;
    if ({bus.ram_we_o, bus.io_we_o, bus.io_re_o} !== 3'b000)
      $display("FAIL reset_strobes: got %b expected 000", {bus.ram_we_o, bus.io_we_o, bus.io_re_o});
    else n_pass++;
    n_checks++;
    if ({bus.cpu_hold_o, bus.dbg_ack_o, bus.fsm_state_o} !== 3'b000)
      $display("FAIL reset_hold_ack_state: got %b expected 000", {bus.cpu_hold_o, bus.dbg_ack_o, bus.fsm_state_o});
    else n_pass++;
    n_checks++;
    if (bus.dbg_rdata_o !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", bus.dbg_rdata_o);
    else n_pass++;
    tick();
    rst = 0;
    drive_idle();
    tick();
  endtask

  task automatic test_cpu_ram();
    bus.cpu_req_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 5'h03; bus.cpu_wdata_i = 8'hA5;
    #4;
    n_checks++;
    if ({bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o, bus.cpu_hold_o} !== {1'b1, 4'h3, 8'hA5, 1'b0})
      $display("FAIL cpu_ram_write: got we=%b a=%h d=%h hold=%b expected 1 3 a5 0",
               bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o, bus.cpu_hold_o);
    else n_pass++;
    tick();
    bus.cpu_we_i = 0;
    #4;
    n_checks++;
    if ({bus.ram_we_o, bus.cpu_rdata_o, bus.cpu_hold_o} !== {1'b0, 8'hA5, 1'b0})
      $display("FAIL cpu_ram_read: got we=%b rdata=%h hold=%b expected 0 a5 0",
               bus.ram_we_o, bus.cpu_rdata_o, bus.cpu_hold_o);
    else n_pass++;
    tick();
    drive_idle();
  endtask

  task automatic test_io_decode();
    bus.cpu_req_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 5'h12; bus.cpu_wdata_i = 8'h3C;
    #4;
    n_checks++;
    if ({bus.io_we_o, bus.io_re_o, bus.io_addr_o, bus.io_data_o, bus.ram_we_o} !== {1'b1, 1'b0, 4'h2, 8'h3C, 1'b0})
      $display("FAIL io_write: got iowe=%b iore=%b a=%h d=%h ramwe=%b expected 1 0 2 3c 0",
               bus.io_we_o, bus.io_re_o, bus.io_addr_o, bus.io_data_o, bus.ram_we_o);
    else n_pass++;
    tick();
    bus.cpu_we_i = 0;
    #4;
    n_checks++;
    if ({bus.io_re_o, bus.io_we_o, bus.ram_we_o, bus.cpu_rdata_o} !== {1'b1, 1'b0, 1'b0, 8'h66})
      $display("FAIL io_read: got iore=%b iowe=%b ramwe=%b rdata=%h expected 1 0 0 66",
               bus.io_re_o, bus.io_we_o, bus.ram_we_o, bus.cpu_rdata_o);
    else n_pass++;
    tick();
    drive_idle();
    #4;
    n_checks++;
    if ({bus.ram_we_o, bus.io_we_o, bus.io_re_o} !== 3'b000)
      $display("FAIL no_req_no_strobe: got %b expected 000", {bus.ram_we_o, bus.io_we_o, bus.io_re_o});
    else n_pass++;
    tick();
  endtask

  task automatic test_idle_dbg_read();
    bus.dbg_req_i = 1; bus.dbg_we_i = 0; bus.dbg_addr_i = 5'h03;
    #4;
    n_checks++;
    if ({bus.cpu_hold_o, bus.dbg_ack_o, bus.ram_addr_o} !== {1'b0, 1'b0, 4'h3})
      $display("FAIL dbg_grant_cycle: got hold=%b ack=%b a=%h expected 0 0 3",
               bus.cpu_hold_o, bus.dbg_ack_o, bus.ram_addr_o);
    else n_pass++;
    tick();
    bus.dbg_req_i = 0;
    #4;
    n_checks++;
    if ({bus.dbg_ack_o, bus.fsm_state_o, bus.dbg_rdata_o} !== {1'b1, 1'b1, 8'hA5})
      $display("FAIL dbg_ack_cycle: got ack=%b st=%b rdata=%h expected 1 1 a5",
               bus.dbg_ack_o, bus.fsm_state_o, bus.dbg_rdata_o);
    else n_pass++;
    tick();
    #4;
    n_checks++;
    if ({bus.dbg_ack_o, bus.dbg_rdata_o} !== {1'b0, 8'hA5})
      $display("FAIL dbg_rdata_hold: got ack=%b rdata=%h expected 0 a5", bus.dbg_ack_o, bus.dbg_rdata_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_starvation();
    bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 5'h01;
    bus.dbg_req_i = 1; bus.dbg_we_i = 0; bus.dbg_addr_i = 5'h03;
    for (int c = 0; c <= LIMIT; c++) begin
      #4;
      n_checks++;
      if ({bus.cpu_hold_o, bus.dbg_ack_o} !== {(c == LIMIT), 1'b0})
        $display("FAIL starve_cycle%0d: got hold=%b ack=%b expected %b 0",
                 c, bus.cpu_hold_o, bus.dbg_ack_o, (c == LIMIT));
      else n_pass++;
      tick();
    end
    bus.dbg_req_i = 0;
    #4;
    n_checks++;
    if ({bus.dbg_ack_o, bus.cpu_hold_o, bus.dbg_rdata_o} !== {1'b1, 1'b0, 8'hA5})
      $display("FAIL starve_ack: got ack=%b hold=%b rdata=%h expected 1 0 a5",
               bus.dbg_ack_o, bus.cpu_hold_o, bus.dbg_rdata_o);
    else n_pass++;
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    bit prev_ack;
    prev_ack = 0;
    bus.dbg_req_i = 1; bus.dbg_we_i = 0; bus.dbg_addr_i = 5'h03;
    for (int c = 0; c < 8; c++) begin
      #4;
      n_checks++;
      if (bus.dbg_ack_o !== bit'(c % 2) || (prev_ack && bus.dbg_ack_o))
        $display("FAIL b2b_cycle%0d: got ack=%b expected %0d", c, bus.dbg_ack_o, c % 2);
      else n_pass++;
      prev_ack = bus.dbg_ack_o;
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_in_ack();
    // Build up a partial wait count, then a grant, then reset inside the ack cycle.
    bus.cpu_req_i = 1; bus.dbg_req_i = 1; bus.dbg_addr_i = 5'h03; bus.dbg_we_i = 0;
    tick();
    tick();
    bus.cpu_req_i = 0;
    tick();
    bus.dbg_req_i = 0;
    #2;
    n_checks++;
    if ({bus.dbg_ack_o, bus.dbg_rdata_o} !== {1'b1, 8'hA5})
      $display("FAIL pre_reset_ack: got ack=%b rdata=%h expected 1 a5", bus.dbg_ack_o, bus.dbg_rdata_o);
    else n_pass++;
    rst = 1;
    model_reset();
    #1;
    n_checks++;
    if ({bus.dbg_ack_o, bus.fsm_state_o, bus.dbg_rdata_o} !== {1'b0, 1'b0, 8'h00})
      $display("FAIL async_reset_in_ack: got ack=%b st=%b rdata=%h expected 0 0 00",
               bus.dbg_ack_o, bus.fsm_state_o, bus.dbg_rdata_o);
    else n_pass++;
    #1;
    tick();
    rst = 0;
    tick();
    n_checks++;
    if (bus.dbg_ack_o !== 1'b0) $display("FAIL ack_lost_after_reset: got %b expected 0", bus.dbg_ack_o);
    else n_pass++;
    // Wait count must restart from zero after reset.
    bus.cpu_req_i = 1; bus.dbg_req_i = 1;
    for (int c = 0; c <= LIMIT; c++) begin
      #4;
      n_checks++;
      if (bus.cpu_hold_o !== (c == LIMIT))
        $display("FAIL starve_after_reset_cycle%0d: got hold=%b expected %b", c, bus.cpu_hold_o, (c == LIMIT));
      else n_pass++;
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (rst) model_reset();
      bus.cpu_req_i   = ($urandom_range(0, 3) != 0);
      bus.cpu_addr_i  = 5'($urandom_range(0, 31));
      bus.cpu_we_i    = ($urandom_range(0, 2) == 0);
      bus.cpu_wdata_i = 8'($urandom_range(0, 255));
      bus.dbg_req_i   = m_ack ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      bus.dbg_addr_i  = 5'($urandom_range(0, 31));
      bus.dbg_we_i    = ($urandom_range(0, 1) == 1);
      bus.dbg_wdata_i = 8'($urandom_range(0, 255));
      #4;
      calc_exp();
      n_checks++;
      if ({bus.ram_we_o, bus.io_we_o, bus.io_re_o, bus.cpu_hold_o, bus.dbg_ack_o, bus.fsm_state_o} !==
          {e_ram_we, e_io_we, e_io_re, e_hold, m_ack, m_ack})
        $display("FAIL rand%0d_ctrl: got %b expected %b", c,
                 {bus.ram_we_o, bus.io_we_o, bus.io_re_o, bus.cpu_hold_o, bus.dbg_ack_o, bus.fsm_state_o},
                 {e_ram_we, e_io_we, e_io_re, e_hold, m_ack, m_ack});
      else n_pass++;
      n_checks++;
      if ({bus.ram_addr_o, bus.io_addr_o, bus.ram_data_o, bus.io_data_o} !== {e_addr, e_addr, e_wdata, e_wdata})
        $display("FAIL rand%0d_bus: got %h expected %h", c,
                 {bus.ram_addr_o, bus.io_addr_o, bus.ram_data_o, bus.io_data_o}, {e_addr, e_addr, e_wdata, e_wdata});
      else n_pass++;
      n_checks++;
      if ({bus.cpu_rdata_o, bus.dbg_rdata_o} !== {e_cpu_rdata, m_rdata})
        $display("FAIL rand%0d_rdata: got cpu=%h dbg=%h expected cpu=%h dbg=%h", c,
                 bus.cpu_rdata_o, bus.dbg_rdata_o, e_cpu_rdata, m_rdata);
      else n_pass++;
      tick();
    end
    rst = 0;
    drive_idle();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 8'h00; io_mem[i] = 8'h00;
      m_ram[i] = 8'h00;   m_io[i] = 8'h00;
    end
    model_reset();
    rst = 1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cpu_ram();
    test_io_decode();
    test_idle_dbg_read();
    test_starvation();
    test_back_to_back();
    test_reset_in_ack();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
